// File: rtl/pipeline_arbiter_round_robin_if.sv
// Handshake bundle for pipeline_arbiter_round_robin: per-requester ready/valid inputs and one buffered output.
// Carries input_last/output_last only when PIPELINE_ARBITER_PACKET_LOCK_EN is defined.
interface pipeline_arbiter_round_robin_if #(
    parameter int WORD_WIDTH   = 8,
    parameter int INPUT_COUNT  = 4,
    parameter int SOURCE_WIDTH = 2
);
    logic [INPUT_COUNT-1:0]            input_valid;
    logic [INPUT_COUNT-1:0]            input_ready;
    logic [INPUT_COUNT*WORD_WIDTH-1:0] input_data;
    logic                              output_valid;
    logic                              output_ready;
    logic [WORD_WIDTH-1:0]             output_data;
    logic [SOURCE_WIDTH-1:0]           output_source;
`ifdef PIPELINE_ARBITER_PACKET_LOCK_EN
    logic [INPUT_COUNT-1:0]            input_last;
    logic                              output_last;

    // master: requesters plus downstream consumer; slave: the arbiter
    modport master (
        output input_valid, input_data, input_last, output_ready,
        input  input_ready, output_valid, output_data, output_source, output_last
    );
    modport slave (
        input  input_valid, input_data, input_last, output_ready,
        output input_ready, output_valid, output_data, output_source, output_last
    );
`else
    modport master (
        output input_valid, input_data, output_ready,
        input  input_ready, output_valid, output_data, output_source
    );
    modport slave (
        input  input_valid, input_data, output_ready,
        output input_ready, output_valid, output_data, output_source
    );
`endif
endinterface

// File: rtl/pipeline_arbiter_round_robin.sv
// Round-robin arbiter feeding a single half-buffer stage shared by INPUT_COUNT requesters.
// Optional packet lock (hold grant until input_last) enabled by PIPELINE_ARBITER_PACKET_LOCK_EN.
module pipeline_arbiter_round_robin #(
    parameter int WORD_WIDTH   = 8,
    parameter int INPUT_COUNT  = 4,
    parameter int SOURCE_WIDTH = 2
) (
    input logic                          clock,
    input logic                          clear,
    pipeline_arbiter_round_robin_if.slave bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                  state_reg;
    logic [SOURCE_WIDTH-1:0] pointer_reg;
    logic                    output_valid_reg;
    logic [WORD_WIDTH-1:0]   output_data_reg;
    logic [SOURCE_WIDTH-1:0] output_source_reg;

    logic [WORD_WIDTH-1:0]   word_array [INPUT_COUNT];
    logic                    grant_found;
    logic [SOURCE_WIDTH-1:0] grant_index;
    logic [SOURCE_WIDTH-1:0] next_pointer;
    logic [SOURCE_WIDTH:0]   search_sum;
    logic [SOURCE_WIDTH-1:0] search_index;
    logic                    load_enable;

`ifdef PIPELINE_ARBITER_PACKET_LOCK_EN
    logic                    lock_reg;
    logic [SOURCE_WIDTH-1:0] lock_source_reg;
    logic                    output_last_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < INPUT_COUNT; gi++) begin : g_slice
            assign word_array[gi] = bus.input_data[gi*WORD_WIDTH +: WORD_WIDTH];
        end
    endgenerate

    // Search starts at the priority pointer and wraps; the first valid requester wins.
    always_comb begin
        grant_found  = 1'b0;
        grant_index  = pointer_reg;
        search_sum   = '0;
        search_index = '0;
        for (int k = 0; k < INPUT_COUNT; k++) begin
            search_sum = {1'b0, pointer_reg} + (SOURCE_WIDTH+1)'(k);
            if (search_sum >= (SOURCE_WIDTH+1)'(INPUT_COUNT)) begin
                search_sum = search_sum - (SOURCE_WIDTH+1)'(INPUT_COUNT);
            end
            search_index = search_sum[SOURCE_WIDTH-1:0];
            if (!grant_found && bus.input_valid[search_index]) begin
                grant_found = 1'b1;
                grant_index = search_index;
            end
        end
`ifdef PIPELINE_ARBITER_PACKET_LOCK_EN
        // Mid-packet, only the locked requester may be granted.
        if (lock_reg) begin
            grant_found = bus.input_valid[lock_source_reg];
            grant_index = lock_source_reg;
        end
`endif
    end

    assign next_pointer = (grant_index == SOURCE_WIDTH'(INPUT_COUNT - 1)) ? '0
                                                                         : grant_index + 1'b1;
    assign load_enable  = (state_reg == EMPTY) && !clear && grant_found;

    generate
        for (gi = 0; gi < INPUT_COUNT; gi++) begin : g_ready
            assign bus.input_ready[gi] = load_enable && (grant_index == SOURCE_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg         <= EMPTY;
            pointer_reg       <= '0;
            output_valid_reg  <= 1'b0;
            output_data_reg   <= '0;
            output_source_reg <= '0;
`ifdef PIPELINE_ARBITER_PACKET_LOCK_EN
            lock_reg          <= 1'b0;
            lock_source_reg   <= '0;
            output_last_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (load_enable) begin
                        state_reg         <= FULL;
                        output_valid_reg  <= 1'b1;
                        output_data_reg   <= word_array[grant_index];
                        output_source_reg <= grant_index;
`ifdef PIPELINE_ARBITER_PACKET_LOCK_EN
                        output_last_reg   <= bus.input_last[grant_index];
                        if (bus.input_last[grant_index]) begin
                            lock_reg    <= 1'b0;
                            pointer_reg <= next_pointer;
                        end else begin
                            lock_reg        <= 1'b1;
                            lock_source_reg <= grant_index;
                        end
`else
                        pointer_reg       <= next_pointer;
`endif
                    end
                end
                FULL: begin
                    // Data and source stay put after the word leaves.
                    if (bus.output_ready) begin
                        state_reg        <= EMPTY;
                        output_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg        <= EMPTY;
                    output_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.output_valid  = output_valid_reg;
    assign bus.output_data   = output_data_reg;
    assign bus.output_source = output_source_reg;
`ifdef PIPELINE_ARBITER_PACKET_LOCK_EN
    assign bus.output_last   = output_last_reg;
`endif

endmodule

// File: tb/tb_pipeline_arbiter_round_robin.sv
// Scoreboard bench for pipeline_arbiter_round_robin: directed scenarios followed by random traffic.
// Reference model tracks EMPTY/FULL, priority pointer and packet lock from the arbitration rules.
module tb_pipeline_arbiter_round_robin;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SW = 2;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    pipeline_arbiter_round_robin_if #(.WORD_WIDTH(W), .INPUT_COUNT(N), .SOURCE_WIDTH(SW)) bus ();

    pipeline_arbiter_round_robin #(
        .WORD_WIDTH(W), .INPUT_COUNT(N), .SOURCE_WIDTH(SW)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus)
    );

    typedef struct {
        logic [W-1:0] data;
        int           source;
        bit           last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bit           req_valid [N];
    logic [W-1:0] req_data  [N];
    bit           req_last  [N];
    bit           granted   [N];

    bit model_full = 0;
    int model_p = 0;
    bit model_lock = 0;
    int model_lock_src = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_grant();
        int idx;
`ifdef PIPELINE_ARBITER_PACKET_LOCK_EN
        if (model_lock) return req_valid[model_lock_src] ? model_lock_src : -1;
`endif
        for (int k = 0; k < N; k++) begin
            idx = (model_p + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.input_valid[i]         = req_valid[i];
            bus.input_data[i*W +: W]   = req_data[i];
`ifdef PIPELINE_ARBITER_PACKET_LOCK_EN
            bus.input_last[i]          = req_last[i];
`endif
        end
    endtask

    // Evaluated mid-cycle: predicts this cycle's ready bits and what the coming edge does.
    task automatic model_eval();
        logic [N-1:0] exp_ready;
        int g;
        exp_t e;
        exp_ready = '0;
        for (int i = 0; i < N; i++) granted[i] = 0;
        if (clear) begin
            check("ready_during_clear", 32'(bus.input_ready), 0);
            model_full = 0;
            model_p = 0;
            model_lock = 0;
            exp_q.delete();
            return;
        end
        check("output_valid", 32'(bus.output_valid), 32'(model_full));
        if (model_full) begin
            if (bus.output_ready) model_full = 0;
        end else begin
            g = ref_grant();
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                e.data = req_data[g];
                e.source = g;
                e.last = req_last[g];
                exp_q.push_back(e);
                model_full = 1;
                granted[g] = 1;
`ifdef PIPELINE_ARBITER_PACKET_LOCK_EN
                if (req_last[g]) begin
                    model_lock = 0;
                    model_p = (g + 1) % N;
                end else begin
                    model_lock = 1;
                    model_lock_src = g;
                end
`else
                model_p = (g + 1) % N;
`endif
            end
        end
        check("input_ready", 32'(bus.input_ready), 32'(exp_ready));
    endtask

    task automatic step();
        drive();
        @(negedge clock);
        model_eval();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 0;
            req_last[i] = 1;
        end
    endtask

    task automatic drain();
        idle_all();
        bus.output_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Monitor: every output handshake consumes the oldest expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!clear && bus.output_valid && bus.output_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(bus.output_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("output_data", 32'(bus.output_data), 32'(e.data));
                    check("output_source", 32'(bus.output_source), 32'(e.source));
`ifdef PIPELINE_ARBITER_PACKET_LOCK_EN
                    check("output_last", 32'(bus.output_last), 32'(e.last));
`endif
                    $display("out: data=0x%02h source=%0d", bus.output_data, bus.output_source);
                end
            end
        end
    end

    initial begin
        int words;
        int other_grants;
        clear = 1'b1;
        bus.output_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1;
            req_data[i] = 8'(8'hC0 + i);
            req_last[i] = 1;
        end

        // Reset with every requester valid
        step();
        step();
        clear = 1'b0;
        idle_all();
        drive();
        #1;
        check("reset_output_valid", 32'(bus.output_valid), 0);
        check("reset_output_data", 32'(bus.output_data), 0);
        check("reset_output_source", 32'(bus.output_source), 0);
        step();

        // Single requester 2 streaming 0xA5
        bus.output_ready = 1'b1;
        req_valid[2] = 1;
        req_data[2] = 8'hA5;
        repeat (8) step();
        drain();

        // Full contention from a cleared pointer
        pulse_clear();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1;
            req_data[i] = 8'(8'h10 + i);
        end
        bus.output_ready = 1'b1;
        repeat (12) step();
        drain();

        // Backpressure holding 0x55 from requester 1
        pulse_clear();
        bus.output_ready = 1'b0;
        req_valid[1] = 1;
        req_data[1] = 8'h55;
        step();
        req_valid[1] = 0;
        req_valid[0] = 1;
        req_data[0] = 8'h44;
        req_valid[2] = 1;
        req_data[2] = 8'h66;
        for (int c = 0; c < 5; c++) begin
            step();
            check("backpressure_hold_data", 32'(bus.output_data), 32'h55);
            check("backpressure_hold_source", 32'(bus.output_source), 1);
        end
        bus.output_ready = 1'b1;
        step();
        step();
        drain();

        // Clear while FULL with 0x77 from requester 3
        pulse_clear();
        bus.output_ready = 1'b0;
        req_valid[3] = 1;
        req_data[3] = 8'h77;
        step();
        check("full_before_clear_data", 32'(bus.output_data), 32'h77);
        req_valid[3] = 0;
        pulse_clear();
        check("after_clear_valid", 32'(bus.output_valid), 0);
        check("after_clear_data", 32'(bus.output_data), 0);
        check("after_clear_source", 32'(bus.output_source), 0);
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1;
            req_data[i] = 8'(8'h20 + i);
        end
        bus.output_ready = 1'b1;
        repeat (4) step();
        drain();

`ifdef PIPELINE_ARBITER_PACKET_LOCK_EN
        // Requester 0 packet of three words while requester 1 contends
        pulse_clear();
        bus.output_ready = 1'b1;
        words = 0;
        other_grants = 0;
        req_valid[0] = 1; req_data[0] = 8'h01; req_last[0] = 0;
        req_valid[1] = 1; req_data[1] = 8'h81; req_last[1] = 1;
        for (int c = 0; c < 30 && other_grants == 0; c++) begin
            step();
            if (granted[1]) begin
                other_grants++;
                check("packet_words_before_other", 32'(words), 3);
                req_valid[1] = 0;
            end
            if (granted[0]) begin
                words++;
                req_data[0] = 8'(words + 1);
                req_last[0] = (words == 2);
                if (words == 3) req_valid[0] = 0;
            end
        end
        check("packet_other_granted", 32'(other_grants), 1);
        drain();
`endif

        // Random traffic with occasional clears
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (granted[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_data[i] = 8'($urandom);
                    req_last[i] = ($urandom_range(0, 2) == 0);
                end
            end
            bus.output_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 199) == 0);
            step();
        end
        clear = 1'b0;
        drain();
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_arbiter_round_robin.md
# pipeline_arbiter_round_robin

Shares one ready/valid half-buffer stage between `INPUT_COUNT` upstream requesters. A round-robin arbiter picks one valid requester whenever the internal buffer is empty, loads its word, and presents it downstream with the index of its source. It sits in front of a shared consumer, such as a single compute unit or output port, that several pipelines must take turns feeding. There is no combinational path from the output handshake to any input handshake.

## Interface
- `WORD_WIDTH`, 8, data word width in bits
- `INPUT_COUNT`, 4, number of requesters, at least 2
- `SOURCE_WIDTH`, 2, width of the source index; must equal clog2(`INPUT_COUNT`)

- `clock`  in  1  single clock; all state updates on the rising edge
- `clear`  in  1  synchronous, active-high reset
- `input_valid`  in  `INPUT_COUNT`  per-requester valid
- `input_ready`  out  `INPUT_COUNT`  per-requester ready; one-hot or zero
- `input_data`  in  `INPUT_COUNT*WORD_WIDTH`  requester i occupies bits [i*WORD_WIDTH +: WORD_WIDTH]
- `output_valid`  out  1  buffer full
- `output_ready`  in  1  downstream accepts
- `output_data`  out  `WORD_WIDTH`  buffered word
- `output_source`  out  `SOURCE_WIDTH`  index of the requester that supplied `output_data`
- `input_last`  in  `INPUT_COUNT`  end of packet, per requester; present only with `PIPELINE_ARBITER_PACKET_LOCK_EN`
- `output_last`  out  1  buffered copy of the granted `input_last`; present only with `PIPELINE_ARBITER_PACKET_LOCK_EN`

## Operation
- Two states: EMPTY and FULL. Reset state is EMPTY.
- Priority pointer `P` (0..`INPUT_COUNT`-1). The grant goes to the first i with `input_valid[i]` set, searching i = P, P+1, … with modulo wrap-around.
- In EMPTY:
  - `input_ready[g]` = 1 only for the granted index g; all other ready bits are 0.
  - If no input is valid, all ready bits are 0.
  - `input_ready` may depend combinationally on `input_valid`. This is the only combinational path in the block.
- Input handshake on g:
  - Load `input_data[g]` into `output_data` and g into `output_source`.
  - Move to FULL.
  - Set P = (g+1) mod `INPUT_COUNT`.
- In FULL:
  - All `input_ready` are 0.
  - `output_valid` = 1.
  - An output handshake returns the block to EMPTY.
- `output_data` and `output_source` hold their values until the next load. They do not clear on output.
- Each requester must hold its data stable while it is valid and not yet granted. The arbiter never drops a valid word.

## Timing
- Reset values: `output_valid`=0, `output_data`=0, `output_source`=0, `output_last`=0, `input_ready`=0 (while `clear` is high), P=0, lock released.
- Latency: an input handshake in cycle N gives `output_valid`=1 in cycle N+1.
- Throughput: at most one word per 2 cycles. An output handshake in cycle N makes EMPTY visible in N+1; the earliest next input handshake is in N+1.
- An input and an output handshake never occur in the same cycle.
- `clear` has priority over everything:
  - Any buffered word is discarded.
  - P returns to 0 and the lock is released.
  - `input_ready` is forced to 0 in the cycle `clear` is asserted, so no handshake completes in that cycle.
- Wrap-around: a grant to `INPUT_COUNT`-1 sets P=0.

## Configuration
- `PIPELINE_ARBITER_PACKET_LOCK_EN` defined:
  - Adds `input_last` and `output_last`.
  - After a grant to g with `input_last[g]`=0, the arbiter locks to g. Subsequent EMPTY cycles grant only g, whatever the other valids.
  - The lock is released when a word with `input_last[g]`=1 is loaded.
  - P advances only on that release, to (g+1) mod `INPUT_COUNT`.
- Not defined:
  - No lock; every word is arbitrated independently.
  - The `input_last` and `output_last` ports do not exist.

## Test plan
- Reset then idle: hold `clear` 2 cycles with all valids high. Required: all ready bits 0 during clear; afterwards `output_valid`=0, `output_data`=0, P=0.
- Single requester: `WORD_WIDTH`=8, requester 2 holds valid with 0xA5 and downstream is always ready. Required: `output_data`=0xA5 and `output_source`=2, one word every 2 cycles, `input_ready` only ever 0b0100.
- Full contention: all 4 valid with data 0x10..0x13 and downstream always ready. Required: source order 0,1,2,3,0,1 with matching data; P wraps from 3 to 0.
- Backpressure: load 0x55 from requester 1 and hold `output_ready`=0 for 5 cycles. Required: `output_valid` stays 1, `output_data` stays 0x55, all ready bits stay 0; one cycle after `output_ready` is raised, the next grant goes to requester 2 if it is valid.
- Clear mid-operation: with the buffer FULL holding 0x77 from source 3, pulse `clear` for 1 cycle. Required: next cycle `output_valid`=0, `output_data`=0, and the next grant starts search at 0.
- Packet lock (macro defined): requester 0 sends a 3-word packet 0x01, 0x02, 0x03 with last on the third, while requester 1 is valid throughout. Required: outputs 0x01, 0x02, 0x03 all from source 0, then requester 1 is granted; `output_last`=1 only with 0x03.
